// File: rtl/ioctl_loader.sv
`timescale 1ns / 1ps
// ioctl_loader: turns the hps_io byte-download stream into bounded write
// strobes for the system, holding the core in reset for the whole download
// plus a fixed tail.
//
// Ports
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout/index   download stream from hps_io
//   dn_addr/dn_data/dn_wr     registered write port to system memory
//   dn_index                  index latched at the start of a download
//   core_reset, load_busy     high while loading or in the post-load hold
//   load_done                 one-cycle completion pulse
//   load_error                sticky: a write fell outside the index limit
//   byte_count, checksum      bytes written and their mod-256 sum
module ioctl_loader #(
    parameter int unsigned BIOS_SIZE   = 16384,
    parameter int unsigned FONT_SIZE   = 2048,
    parameter int unsigned POST_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  dn_index,
    output logic        core_reset,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [24:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int unsigned     CntW    = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(POST_CYCLES - 1);
    localparam logic [24:0]     BiosLim = 25'(BIOS_SIZE);
    localparam logic [24:0]     FontLim = 25'(FONT_SIZE);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StPost = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            dl_q;
    logic            armed_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [13:0]     dn_addr_q, dn_addr_d;
    logic [7:0]      dn_data_q, dn_data_d;
    logic            dn_wr_q, dn_wr_d;
    logic [7:0]      dn_index_q, dn_index_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [24:0]     count_q, count_d;
    logic [7:0]      sum_q, sum_d;

    logic        rise, fall, start;
    logic [24:0] limit;

    // armed_q stays low for the first cycle after reset so a download level
    // that is already high is absorbed into dl_q instead of looking like an edge.
    assign rise  = armed_q & ioctl_download & ~dl_q;
    assign fall  = dl_q & ~ioctl_download;
    assign start = rise && (ioctl_index < 8'd2);
    assign limit = (dn_index_q == 8'd0) ? BiosLim : FontLim;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        dn_wr_d    = 1'b0;
        dn_index_d = dn_index_q;
        error_d    = error_q;
        count_d    = count_q;
        sum_d      = sum_q;

        case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (ioctl_wr) begin
                    if (ioctl_addr < limit) begin
                        dn_wr_d   = 1'b1;
                        dn_addr_d = ioctl_addr[13:0];
                        dn_data_d = ioctl_dout;
                        sum_d     = sum_q + ioctl_dout;
                        if (count_q != '1) count_d = count_q + 25'd1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (fall) begin
                    state_d = StPost;
                    cnt_d   = CntLoad;
                end
            end
            StPost: begin
                // A new download restarts loading without dropping core_reset.
                if (start) begin
                    state_d = StLoad;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start && (state_q == StIdle || state_q == StPost)) begin
            dn_index_d = ioctl_index;
            error_d    = 1'b0;
            count_d    = '0;
            sum_d      = '0;
        end

        busy_d = (state_d == StLoad) || (state_d == StPost);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            dn_wr_q    <= 1'b0;
            dn_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            armed_q    <= 1'b1;
            cnt_q      <= cnt_d;
            dn_addr_q  <= dn_addr_d;
            dn_data_q  <= dn_data_d;
            dn_wr_q    <= dn_wr_d;
            dn_index_q <= dn_index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign dn_index   = dn_index_q;
    assign core_reset = busy_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign byte_count = count_q;
    assign checksum   = sum_q;

endmodule

// File: tb/tb_ioctl_loader.sv
`timescale 1ns / 1ps
// Self-checking bench for ioctl_loader: directed scenarios followed by random
// downloads, compared against a byte-level model of what the loader should do.
module tb_ioctl_loader;

    localparam int unsigned BIOS = 16384;
    localparam int unsigned FONT = 2048;
    localparam int unsigned POST = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [7:0]  dn_index;
    logic        core_reset;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [24:0] byte_count;
    logic [7:0]  checksum;

    ioctl_loader #(
        .BIOS_SIZE  (BIOS),
        .FONT_SIZE  (FONT),
        .POST_CYCLES(POST)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr         (dn_wr),
        .dn_index      (dn_index),
        .core_reset    (core_reset),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .byte_count    (byte_count),
        .checksum      (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_seen  = 0;
    int done_seen = 0;
    int exp_wr_total = 0;

    // Model of the loader's visible state
    bit          loading = 0;
    int unsigned exp_cnt = 0;
    int unsigned exp_sum = 0;
    bit          exp_err = 0;
    int unsigned exp_idx = 0;
    int unsigned exp_addr = 0;
    int unsigned exp_data = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (dn_wr === 1'b1) wr_seen++;
        if (load_done === 1'b1) done_seen++;
    endtask

    function automatic int unsigned lim_of(input int unsigned idx);
        return (idx == 0) ? BIOS : FONT;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".byte_count"}, 32'(byte_count), exp_cnt);
        check({tag, ".checksum"}, 32'(checksum), exp_sum % 256);
        check({tag, ".load_error"}, 32'(load_error), 32'(exp_err));
        check({tag, ".dn_index"}, 32'(dn_index), exp_idx);
        check({tag, ".dn_addr"}, 32'(dn_addr), exp_addr);
        check({tag, ".dn_data"}, 32'(dn_data), exp_data);
    endtask

    // Apply the model effect of one byte strobe seen by the loader.
    task automatic model_byte(input int unsigned addr, input int unsigned data, output bit acc);
        acc = loading && (addr < lim_of(exp_idx));
        if (loading && !acc) exp_err = 1;
        if (acc) begin
            if (exp_cnt != 32'h1FF_FFFF) exp_cnt = exp_cnt + 1;
            exp_sum  = exp_sum + data;
            exp_addr = addr % 16384;
            exp_data = data;
            exp_wr_total++;
        end
    endtask

    task automatic start_dl(input int unsigned idx, input bit from_post);
        ioctl_download = 1'b1;
        ioctl_index    = 8'(idx);
        tick();
        if (idx < 2) begin
            loading = 1;
            exp_idx = idx;
            exp_cnt = 0;
            exp_sum = 0;
            exp_err = 0;
        end
        check("start.core_reset", 32'(core_reset), 32'((idx < 2) || from_post));
        check("start.load_busy", 32'(load_busy), 32'((idx < 2) || from_post));
        check_regs("start");
    endtask

    task automatic wr_byte(input int unsigned addr, input int unsigned data, input int gap);
        bit acc;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = 8'(data);
        tick();
        ioctl_wr = 1'b0;
        model_byte(addr, data, acc);
        check("wr.dn_wr", 32'(dn_wr), 32'(acc));
        check_regs("wr");
        for (int g = 0; g < gap; g++) begin
            tick();
            check("gap.dn_wr", 32'(dn_wr), 0);
        end
    endtask

    task automatic end_dl(input bit with_wr, input int unsigned addr, input int unsigned data);
        bit acc;
        bit was_loading;
        was_loading    = loading;
        ioctl_download = 1'b0;
        ioctl_wr       = with_wr;
        ioctl_addr     = 25'(addr);
        ioctl_dout     = 8'(data);
        tick();
        ioctl_wr = 1'b0;
        acc = 0;
        if (with_wr) model_byte(addr, data, acc);
        loading = 0;
        check("end.dn_wr", 32'(dn_wr), 32'(acc));
        check("end.core_reset", 32'(core_reset), 32'(was_loading));
        check("end.load_done", 32'(load_done), 0);
        check_regs("end");
    endtask

    // Expects the sample right after the falling edge to be the first hold cycle.
    task automatic wait_done();
        int n;
        int d0;
        n  = 0;
        d0 = done_seen;
        while (core_reset === 1'b1 && n < int'(POST) + 8) begin
            tick();
            n++;
        end
        check("post.length", 32'(n), POST);
        check("post.load_done", 32'(load_done), 1);
        check("post.done_count", 32'(done_seen - d0), 1);
        tick();
        check("idle.load_done", 32'(load_done), 0);
        check("idle.load_busy", 32'(load_busy), 0);
        check_regs("idle");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dn_addr"}, 32'(dn_addr), 0);
        check({tag, ".dn_data"}, 32'(dn_data), 0);
        check({tag, ".dn_wr"}, 32'(dn_wr), 0);
        check({tag, ".dn_index"}, 32'(dn_index), 0);
        check({tag, ".core_reset"}, 32'(core_reset), 0);
        check({tag, ".load_busy"}, 32'(load_busy), 0);
        check({tag, ".load_done"}, 32'(load_done), 0);
        check({tag, ".load_error"}, 32'(load_error), 0);
        check({tag, ".byte_count"}, 32'(byte_count), 0);
        check({tag, ".checksum"}, 32'(checksum), 0);
    endtask

    initial begin
        int w0, d0, nw, idx, lim, r, addr;

        // Power-on reset
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // BIOS download of three bytes
        w0 = wr_seen;
        start_dl(0, 0);
        wr_byte(0, 8'h01, 1);
        wr_byte(1, 8'h02, 2);
        wr_byte(2, 8'h03, 1);
        end_dl(0, 0, 0);
        check("bios.byte_count", 32'(byte_count), 3);
        check("bios.checksum", 32'(checksum), 32'h06);
        check("bios.wr_pulses", 32'(wr_seen - w0), 3);
        wait_done();

        // Font limit boundary
        start_dl(1, 0);
        wr_byte(2048, 8'hAA, 1);
        check("font.err_set", 32'(load_error), 1);
        check("font.cnt_held", 32'(byte_count), 0);
        wr_byte(2047, 8'h55, 1);
        check("font.accept2047", 32'(byte_count), 1);
        check("font.err_sticky", 32'(load_error), 1);
        end_dl(0, 0, 0);
        wait_done();

        // Unsupported index: fully ignored
        w0 = wr_seen;
        d0 = done_seen;
        start_dl(2, 0);
        for (int i = 0; i < 10; i++) wr_byte(i, i + 1, 0);
        end_dl(0, 0, 0);
        repeat (POST + 4) tick();
        check("idx2.no_wr", 32'(wr_seen - w0), 0);
        check("idx2.no_done", 32'(done_seen - d0), 0);
        check("idx2.core_reset", 32'(core_reset), 0);

        // Write coincident with the falling edge
        start_dl(0, 0);
        wr_byte(5, 8'h10, 1);
        end_dl(1, 6, 8'h77);
        check("coinc.count", 32'(byte_count), 2);
        check("coinc.sum", 32'(checksum), 32'h87);
        wait_done();

        // Restart during the post-load hold
        d0 = done_seen;
        start_dl(1, 0);
        wr_byte(100, 8'h20, 1);
        end_dl(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("restart.hold", 32'(core_reset), 1);
        end
        start_dl(0, 1);
        wr_byte(7, 8'h33, 0);
        wr_byte(8, 8'h44, 1);
        end_dl(0, 0, 0);
        wait_done();
        check("restart.one_done", 32'(done_seen - d0), 1);

        // Random downloads
        for (int t = 0; t < 24; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) idx = 0;
            else if (r < 8) idx = 1;
            else idx = int'($urandom_range(2, 255));
            d0 = done_seen;
            start_dl(idx, 0);
            nw  = int'($urandom_range(1, 12));
            lim = (idx == 0) ? int'(BIOS) : int'(FONT);
            for (int i = 0; i < nw; i++) begin
                r = int'($urandom_range(0, 19));
                if (r < 14) addr = int'($urandom_range(0, lim - 1));
                else if (r < 17) addr = lim - 2 + int'($urandom_range(0, 3));
                else addr = int'($urandom & 32'h1FF_FFFF);
                wr_byte(addr, $urandom_range(0, 255), int'($urandom_range(0, 3)));
            end
            r = int'($urandom_range(0, 1));
            end_dl(r[0], $urandom_range(0, lim + 1), $urandom_range(0, 255));
            if (idx < 2) begin
                wait_done();
            end else begin
                repeat (3) tick();
                check("rand.idx_ignored", 32'(done_seen - d0), 0);
            end
        end

        // Asynchronous reset in the middle of a load
        start_dl(0, 0);
        wr_byte(9, 8'h5A, 1);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        loading  = 0;
        exp_cnt  = 0;
        exp_sum  = 0;
        exp_err  = 0;
        exp_idx  = 0;
        exp_addr = 0;
        exp_data = 0;
        check_all_zero("async_reset");
        tick();
        reset_n = 1'b1;
        // Download level still high: must not count as a new edge
        w0 = wr_seen;
        for (int i = 0; i < 4; i++) begin
            wr_byte(i, 8'hC0 + i, 1);
            check("postreset.core_reset", 32'(core_reset), 0);
        end
        end_dl(0, 0, 0);
        check("postreset.no_wr", 32'(wr_seen - w0), 0);

        // Fresh edge works again
        start_dl(0, 0);
        wr_byte(3, 8'h99, 1);
        end_dl(0, 0, 0);
        wait_done();

        check("total.dn_wr_pulses", 32'(wr_seen), 32'(exp_wr_total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 Parameters SHALL be:
- BIOS_SIZE, default 16384, byte limit for index 0.
- FONT_SIZE, default 2048, byte limit for index 1.
- POST_CYCLES, default 16, clk_sys cycles that core_reset is held after download ends (minimum 1).

REQ-002 Ports SHALL be:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download-active level from hps_io.
- ioctl_wr  in  1  single-cycle byte strobe from hps_io.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  file index (0 BIOS, 1 font).
- dn_addr  out  14  write address to system.
- dn_data  out  8  write data to system.
- dn_wr  out  1  single-cycle write strobe to system.
- dn_index  out  8  latched index of the current download.
- core_reset  out  1  active-high hold for system.
- load_busy  out  1  high in LOAD or POST.
- load_done  out  1  one-cycle completion pulse.
- load_error  out  1  sticky out-of-range flag for the last download.
- byte_count  out  25  bytes written in the last or current download.
- checksum  out  8  mod-256 sum of bytes written.

REQ-003 Clock and reset SHALL be one clock, clk_sys, and reset_n, which is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD, POST, DONE.

REQ-005 A download edge SHALL be detected by comparing ioctl_download with a 1-cycle registered copy.

REQ-006 From IDLE or POST, a rising edge with ioctl_index < 2 SHALL do all of the following in the same cycle:
- Enter LOAD.
- Latch dn_index.
- Clear byte_count, checksum and load_error.

REQ-007 A rising edge with ioctl_index >= 2 SHALL be ignored: the state is unchanged and no dn_wr is produced for that download.

REQ-008 In LOAD, an ioctl_wr whose ioctl_addr < limit(dn_index) SHALL produce, exactly one cycle later:
- dn_wr = 1.
- dn_addr = ioctl_addr[13:0].
- dn_data = ioctl_dout.
On the same accept edge it SHALL also increment byte_count by 1 and add ioctl_dout to checksum (mod 256).

REQ-009 In LOAD, an ioctl_wr with ioctl_addr >= limit SHALL:
- Set load_error.
- Produce no dn_wr.
- Leave byte_count and checksum unchanged.

REQ-010 ioctl_wr SHALL be ignored in IDLE, POST and DONE.

REQ-011 A falling edge of ioctl_download in LOAD SHALL enter POST and load a down-counter with POST_CYCLES-1. An ioctl_wr in that same cycle SHALL still be processed per REQ-008/009.

REQ-012 POST SHALL decrement the counter each cycle and enter DONE when the counter is 0, so POST lasts exactly POST_CYCLES cycles.

REQ-013 DONE SHALL last one cycle, assert load_done during it, and return to IDLE.

REQ-014 core_reset and load_busy SHALL be registered and high exactly while in LOAD or POST.

REQ-015 dn_wr SHALL never be high on two consecutive cycles unless ioctl_wr was high on two consecutive accepted cycles.

REQ-016 byte_count SHALL saturate at all-ones instead of wrapping.

REQ-017 dn_addr, dn_data, byte_count, checksum, load_error and dn_index SHALL hold their values between downloads.

Reset
REQ-018 Asserting reset_n = 0 SHALL, asynchronously and in any state including mid-LOAD:
- Put the FSM in IDLE.
- Clear the edge register.
- Set every output to 0.

REQ-019 After reset_n deasserts, if ioctl_download is already high, that SHALL NOT count as a rising edge; the loader waits for a fresh rising edge.

Verification
REQ-020 Reset mid-LOAD → all outputs 0 within the same cycle; no dn_wr after release until a new rising edge.

REQ-021 Index 0 download of bytes 0x01,0x02,0x03 at addresses 0..2, then download falls → the bench SHALL see:
- Three dn_wr pulses, each 1 cycle after its ioctl_wr, with matching addr/data.
- byte_count = 3, checksum = 0x06.
- core_reset high for LOAD plus 16 cycles.
- One load_done pulse.

REQ-022 Index 1 write at address 2048 (FONT_SIZE) → load_error = 1, no dn_wr, byte_count unchanged; a following write at address 2047 is accepted.

REQ-023 Index 2 download with 10 ioctl_wr strobes → no dn_wr, core_reset stays 0, no load_done.

REQ-024 ioctl_wr coincident with the download falling edge → that byte is written and counted, then POST starts.

REQ-025 New rising edge (index 0) during POST → immediate return to LOAD, counters cleared, core_reset continuously high, exactly one load_done at the end of the second download.
